// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Purpose  : VGA pixel/line counters with sync, blanking and start pulses.
//            Define VGA_SYNC_DELAY_EN to register hsync/vsync one extra clock.
// Revision : 1.0
// ============================================================================
module vga_timing_gen #(
  parameter int H_VIDEO = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_VIDEO = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33
) (
  input  logic       clk_0,
  input  logic       rst,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_VIDEO + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIDEO + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] C_H_MAX      = 10'(H_TOTAL - 1);
  localparam logic [9:0] C_V_MAX      = 10'(V_TOTAL - 1);
  localparam logic [9:0] C_H_VIDEO    = 10'(H_VIDEO);
  localparam logic [9:0] C_V_VIDEO    = 10'(V_VIDEO);
  localparam logic [9:0] C_HS_START   = 10'(H_VIDEO + H_FP);
  localparam logic [9:0] C_HS_END     = 10'(H_VIDEO + H_FP + H_SYNC);
  localparam logic [9:0] C_VS_START   = 10'(V_VIDEO + V_FP);
  localparam logic [9:0] C_VS_END     = 10'(V_VIDEO + V_FP + V_SYNC);

  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic       h_wrap;
  logic       hsync_raw;
  logic       vsync_raw;

  always_comb begin
    h_wrap = (h_q == C_H_MAX);
    h_d    = h_wrap ? 10'd0 : h_q + 10'd1;
    v_d    = v_q;
    if (h_wrap) begin
      v_d = (v_q == C_V_MAX) ? 10'd0 : v_q + 10'd1;
    end
  end

  always_ff @(posedge clk_0) begin
    if (rst) begin
      h_q <= 10'd0;
      v_q <= 10'd0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  // Sync windows are half-open: [START, END).
  always_comb begin
    hsync_raw = !((h_q >= C_HS_START) && (h_q < C_HS_END));
    vsync_raw = !((v_q >= C_VS_START) && (v_q < C_VS_END));
  end

  assign pixel_x     = h_q;
  assign pixel_y     = v_q;
  assign video_on    = (h_q < C_H_VIDEO) && (v_q < C_V_VIDEO);
  assign line_start  = (h_q == 10'd0);
  assign frame_start = (h_q == 10'd0) && (v_q == 10'd0);

`ifdef VGA_SYNC_DELAY_EN
  logic hsync_q;
  logic vsync_q;

  // Extra stage lines sync up with RGB registered one clock after the counters.
  always_ff @(posedge clk_0) begin
    if (rst) begin
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      hsync_q <= hsync_raw;
      vsync_q <= vsync_raw;
    end
  end

  assign hsync = hsync_q;
  assign vsync = vsync_q;
`else
  assign hsync = hsync_raw;
  assign vsync = vsync_raw;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_vga_timing_gen
// Purpose  : Self-checking bench for vga_timing_gen (default and reduced sizes).
// Revision : 1.0
// ============================================================================
module tb_vga_timing_gen;

  // Reduced geometry so whole frames fit in a short run.
  localparam int SH_VIDEO = 20, SH_FP = 3, SH_SYNC = 5, SH_BP = 4;
  localparam int SV_VIDEO = 10, SV_FP = 2, SV_SYNC = 2, SV_BP = 3;
  localparam int SHT = SH_VIDEO + SH_FP + SH_SYNC + SH_BP;
  localparam int SVT = SV_VIDEO + SV_FP + SV_SYNC + SV_BP;
  localparam int SFRAME = SHT * SVT;

`ifdef VGA_SYNC_DELAY_EN
  localparam bit DLY = 1'b1;
`else
  localparam bit DLY = 1'b0;
`endif

  logic clk_0 = 1'b0;
  always #20 clk_0 = ~clk_0;

  logic       rst_a, rst_b;
  logic [9:0] a_x, a_y, b_x, b_y;
  logic       a_vo, a_hs, a_vs, a_ls, a_fs;
  logic       b_vo, b_hs, b_vs, b_ls, b_fs;

  vga_timing_gen u_def (
    .clk_0(clk_0), .rst(rst_a), .pixel_x(a_x), .pixel_y(a_y), .video_on(a_vo),
    .hsync(a_hs), .vsync(a_vs), .line_start(a_ls), .frame_start(a_fs)
  );

  vga_timing_gen #(
    .H_VIDEO(SH_VIDEO), .H_FP(SH_FP), .H_SYNC(SH_SYNC), .H_BP(SH_BP),
    .V_VIDEO(SV_VIDEO), .V_FP(SV_FP), .V_SYNC(SV_SYNC), .V_BP(SV_BP)
  ) u_sm (
    .clk_0(clk_0), .rst(rst_b), .pixel_x(b_x), .pixel_y(b_y), .video_on(b_vo),
    .hsync(b_hs), .vsync(b_vs), .line_start(b_ls), .frame_start(b_fs)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Hand-computed vectors for the default 800x525 geometry, indexed by clocks since reset.
  typedef struct {
    int t; int x; int y;
    bit vo; bit hs; bit hs_d; bit ls; bit fs;
  } vec_t;

  vec_t vecs[$];

  // Reference model: position is simply elapsed clocks modulo the frame geometry.
  int m_t;
  bit m_hs_q, m_vs_q;

  task automatic ref_raw(input int t, output int x, output int y, output bit vo,
                         output bit hs, output bit vs, output bit ls, output bit fs);
    x  = t % SHT;
    y  = (t / SHT) % SVT;
    vo = (x < SH_VIDEO) && (y < SV_VIDEO);
    hs = !((x >= SH_VIDEO + SH_FP) && (x < SH_VIDEO + SH_FP + SH_SYNC));
    vs = !((y >= SV_VIDEO + SV_FP) && (y < SV_VIDEO + SV_FP + SV_SYNC));
    ls = (x == 0);
    fs = (x == 0) && (y == 0);
  endtask

  task automatic check_sm(input string tag);
    int x, y; bit vo, hs, vs, ls, fs;
    ref_raw(m_t, x, y, vo, hs, vs, ls, fs);
    chk({tag, "_x"},  {22'b0, b_x}, x);
    chk({tag, "_y"},  {22'b0, b_y}, y);
    chk({tag, "_vo"}, {31'b0, b_vo}, {31'b0, vo});
    chk({tag, "_hs"}, {31'b0, b_hs}, {31'b0, DLY ? m_hs_q : hs});
    chk({tag, "_vs"}, {31'b0, b_vs}, {31'b0, DLY ? m_vs_q : vs});
    chk({tag, "_ls"}, {31'b0, b_ls}, {31'b0, ls});
    chk({tag, "_fs"}, {31'b0, b_fs}, {31'b0, fs});
  endtask

  // Called at a negedge: apply rst for the next edge, advance model, return at next negedge.
  task automatic step_b(input bit r);
    int x, y; bit vo, hs, vs, ls, fs;
    rst_b = r;
    @(posedge clk_0);
    ref_raw(m_t, x, y, vo, hs, vs, ls, fs);
    if (r) begin
      m_t = 0; m_hs_q = 1'b1; m_vs_q = 1'b1;
    end else begin
      m_hs_q = hs; m_vs_q = vs; m_t = m_t + 1;
    end
    @(negedge clk_0);
  endtask

  initial begin
    int ta;
    int fs_cnt, ls_cnt, fs_first, fs_second;

    vecs.push_back('{0,    0,   0, 1, 1, 1, 1, 1});
    vecs.push_back('{1,    1,   0, 1, 1, 1, 0, 0});
    vecs.push_back('{2,    2,   0, 1, 1, 1, 0, 0});
    vecs.push_back('{639,  639, 0, 1, 1, 1, 0, 0});
    vecs.push_back('{640,  640, 0, 0, 1, 1, 0, 0});
    vecs.push_back('{655,  655, 0, 0, 1, 1, 0, 0});
    vecs.push_back('{656,  656, 0, 0, 0, 1, 0, 0});
    vecs.push_back('{657,  657, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{751,  751, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{752,  752, 0, 0, 1, 0, 0, 0});
    vecs.push_back('{753,  753, 0, 0, 1, 1, 0, 0});
    vecs.push_back('{799,  799, 0, 0, 1, 1, 0, 0});
    vecs.push_back('{800,  0,   1, 1, 1, 1, 1, 0});
    vecs.push_back('{801,  1,   1, 1, 1, 1, 0, 0});
    vecs.push_back('{1456, 656, 1, 0, 0, 1, 0, 0});
    vecs.push_back('{1600, 0,   2, 1, 1, 1, 1, 0});

    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (3) @(posedge clk_0);
    @(negedge clk_0);

    // Reset-state outputs on both instances.
    chk("rst_x",  {22'b0, a_x}, 0);
    chk("rst_y",  {22'b0, a_y}, 0);
    chk("rst_vo", {31'b0, a_vo}, 1);
    chk("rst_hs", {31'b0, a_hs}, 1);
    chk("rst_vs", {31'b0, a_vs}, 1);
    chk("rst_ls", {31'b0, a_ls}, 1);
    chk("rst_fs", {31'b0, a_fs}, 1);
    m_t = 0; m_hs_q = 1'b1; m_vs_q = 1'b1;
    check_sm("rst_sm");

    // Default geometry: walk the vector table.
    rst_a = 1'b0;
    ta = 0;
    foreach (vecs[i]) begin
      while (ta < vecs[i].t) begin
        @(negedge clk_0);
        ta++;
      end
      chk($sformatf("def_x@%0d", ta),  {22'b0, a_x}, vecs[i].x);
      chk($sformatf("def_y@%0d", ta),  {22'b0, a_y}, vecs[i].y);
      chk($sformatf("def_vo@%0d", ta), {31'b0, a_vo}, {31'b0, vecs[i].vo});
      chk($sformatf("def_hs@%0d", ta), {31'b0, a_hs}, {31'b0, DLY ? vecs[i].hs_d : vecs[i].hs});
      chk($sformatf("def_vs@%0d", ta), {31'b0, a_vs}, 1);
      chk($sformatf("def_ls@%0d", ta), {31'b0, a_ls}, {31'b0, vecs[i].ls});
      chk($sformatf("def_fs@%0d", ta), {31'b0, a_fs}, {31'b0, vecs[i].fs});
    end
    rst_a = 1'b1;

    // Reduced geometry: two full frames, pulse counting and spacing.
    fs_cnt = 0; ls_cnt = 0; fs_first = -1; fs_second = -1;
    for (int n = 0; n < 2 * SFRAME; n++) begin
      check_sm("frm");
      if (b_ls === 1'b1) ls_cnt++;
      if (b_fs === 1'b1) begin
        fs_cnt++;
        if (fs_first < 0) fs_first = n; else if (fs_second < 0) fs_second = n;
      end
      step_b(1'b0);
    end
    chk("fs_count", fs_cnt, 2);
    chk("ls_count", ls_cnt, 2 * SVT);
    chk("fs_spacing", fs_second - fs_first, SFRAME);

    // Double-wrap corner.
    while ((m_t % SFRAME) != SFRAME - 1) step_b(1'b0);
    chk("corner_x", {22'b0, b_x}, SHT - 1);
    chk("corner_y", {22'b0, b_y}, SVT - 1);
    step_b(1'b0);
    chk("wrap_x",  {22'b0, b_x}, 0);
    chk("wrap_y",  {22'b0, b_y}, 0);
    chk("wrap_fs", {31'b0, b_fs}, 1);
    chk("wrap_vo", {31'b0, b_vo}, 1);

    // Reset while both syncs are active.
    while ((m_t % SFRAME) != 12 * SHT + 24) step_b(1'b0);
    chk("mid_hs_low", {31'b0, b_hs}, 0);
    chk("mid_vs_low", {31'b0, b_vs}, 0);
    step_b(1'b1);
    chk("abort_hs", {31'b0, b_hs}, 1);
    chk("abort_vs", {31'b0, b_vs}, 1);
    chk("abort_x",  {22'b0, b_x}, 0);
    chk("abort_y",  {22'b0, b_y}, 0);
    chk("abort_fs", {31'b0, b_fs}, 1);
    step_b(1'b0);
    chk("resume_x",  {22'b0, b_x}, 1);
    chk("resume_fs", {31'b0, b_fs}, 0);
    chk("resume_hs", {31'b0, b_hs}, 1);

    // Random reset pulses against the model.
    for (int n = 0; n < 3000; n++) begin
      step_b($urandom_range(0, 99) == 0);
      check_sm("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
